// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock-inhibit request-to-send,
// bits shifted out on device clock falls, device ACK checked at the end.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES     = 5000,
   parameter int START_SETUP_CYCLES = 100,
   parameter int TIMEOUT_CYCLES     = 750000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int MAXP01 = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES : START_SETUP_CYCLES;
   localparam int MAXP   = (MAXP01 > TIMEOUT_CYCLES) ? MAXP01 : TIMEOUT_CYCLES;
   localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(START_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          parity, par_n;
   logic          dat_r, dat_n;
   logic          done_n, err_n;

   logic clk_d1, clk_d2, clk_d3;
   logic dat_d1, dat_d2;
   logic fall;

   // Synchronizers idle high to match the released (pulled-up) bus.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_d1 <= 1'b1;
         clk_d2 <= 1'b1;
         clk_d3 <= 1'b1;
         dat_d1 <= 1'b1;
         dat_d2 <= 1'b1;
      end else begin
         clk_d1 <= ps2_clk_in;
         clk_d2 <= clk_d1;
         clk_d3 <= clk_d2;
         dat_d1 <= ps2_dat_in;
         dat_d2 <= dat_d1;
      end
   end

   assign fall = ~clk_d2 & clk_d3;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         parity   <= 1'b0;
         dat_r    <= 1'b0;
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
         parity   <= par_n;
         dat_r    <= dat_n;
         tx_done  <= done_n;
         tx_error <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      shift_n = shift;
      par_n   = parity;
      dat_n   = dat_r;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (tx_valid) begin
               shift_n = tx_data;
               par_n   = ~^tx_data;
               cnt_n   = '0;
               bit_n   = '0;
               dat_n   = 1'b0;
               state_n = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt == INH_LAST) begin
               cnt_n   = '0;
               state_n = START;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         START: begin
            if (cnt == SET_LAST) begin
               cnt_n   = '0;
               bit_n   = '0;
               // Start bit stays driven until the device's first fall.
               dat_n   = 1'b1;
               state_n = SEND;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         SEND: begin
            if (fall) begin
               cnt_n = '0;
               bit_n = bit_idx + 4'd1;
               if (bit_idx < 4'd8) begin
                  dat_n = ~shift[bit_idx[2:0]];
               end else if (bit_idx == 4'd8) begin
                  dat_n = ~parity;
               end else begin
                  dat_n   = 1'b0;
                  state_n = ACK;
               end
            end else if (cnt == TO_LAST) begin
               dat_n   = 1'b0;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ACK: begin
            if (fall) begin
               done_n  = ~dat_d2;
               err_n   = dat_d2;
               state_n = IDLE;
            end else if (cnt == TO_LAST) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line drives decode straight from state so reset releases them immediately.
   assign ps2_clk_oe = (state == INHIBIT) || (state == START);
   assign ps2_dat_oe = (state == START) || ((state == SEND) && dat_r);
   assign busy       = (state != IDLE);
   assign tx_ready   = ~busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a simple PS/2 device that
// clocks the bits and drives the ACK.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int SET = 4;
   localparam int TO  = 200;
   localparam int HP  = 40;

   logic       clock = 1'b0;
   logic       resetn;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, tx_done, tx_error;

   logic dev_clk = 1'b1;
   logic dev_dat = 1'b1;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit overlap_seen = 0;
   bit long_seen = 0;
   logic prev_done = 1'b0;
   logic prev_err = 1'b0;

   always #5 clock = ~clock;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_SETUP_CYCLES(SET),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .tx_done(tx_done),
      .tx_error(tx_error)
   );

   always @(negedge clock) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) overlap_seen = 1;
      if ((tx_done && prev_done) || (tx_error && prev_err)) long_seen = 1;
      prev_done = tx_done;
      prev_err  = tx_error;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   // Counts negedges with ps2_clk_oe high, starting at the current one.
   task automatic wait_release(output int n);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clock);
      end
   endtask

   task automatic dev_falls(input int n, input bit ack_hi, output logic [9:0] oe);
      oe = '0;
      for (int f = 0; f < n; f++) begin
         if (f == 10) dev_dat = ack_hi;
         repeat (HP) @(negedge clock);
         dev_clk = 1'b0;
         if (f == 10) begin
            repeat (6) @(negedge clock);
         end else begin
            repeat (5) @(negedge clock);
            oe[f] = ps2_dat_oe;
            repeat (HP - 5) @(negedge clock);
         end
         dev_clk = 1'b1;
         dev_dat = 1'b1;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         ack_hi;
      logic [9:0] exp_oe;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int low, n, d0, e0;
      logic [9:0] oe;

      vecs[0] = '{8'hED, 1'b0, 10'h012, 1, 0};
      vecs[1] = '{8'h01, 1'b0, 10'h1FE, 1, 0};
      vecs[2] = '{8'hFF, 1'b0, 10'h000, 1, 0};
      vecs[3] = '{8'hF4, 1'b1, 10'h10B, 0, 1};

      resetn   = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_error, 0);
      resetn = 1'b1;
      repeat (3) @(negedge clock);

      for (int i = 0; i < 4; i++) begin
         start_tx(vecs[i].data);
         wait_release(low);
         chk("clk_inhibit_len", low, INH + SET);
         chk("start_bit_oe", ps2_dat_oe, 1);
         d0 = done_cnt;
         e0 = err_cnt;
         dev_falls(11, vecs[i].ack_hi, oe);
         repeat (2) @(negedge clock);
         chk("dat_oe_per_fall", oe, vecs[i].exp_oe);
         chk("done_pulses", done_cnt - d0, vecs[i].exp_done);
         chk("err_pulses", err_cnt - e0, vecs[i].exp_err);
         chk("idle_busy", busy, 0);
         chk("idle_ready", tx_ready, 1);
      end

      // Watchdog: device never clocks after release.
      start_tx(8'h55);
      wait_release(low);
      d0 = done_cnt;
      e0 = err_cnt;
      n = 0;
      while (!tx_error && n < 1000) begin
         @(negedge clock);
         n++;
      end
      chk("timeout_latency", n, TO);
      chk("timeout_clk_oe", ps2_clk_oe, 0);
      chk("timeout_dat_oe", ps2_dat_oe, 0);
      chk("timeout_busy", busy, 0);
      @(negedge clock);
      chk("timeout_err_once", err_cnt - e0, 1);
      chk("timeout_no_done", done_cnt - d0, 0);

      // Async reset during bit 4 of 0xED (bit 4 is 0, so data is pulled low).
      start_tx(8'hED);
      wait_release(low);
      dev_falls(5, 1'b0, oe);
      chk("bit4_dat_oe", ps2_dat_oe, 1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_clk_oe", ps2_clk_oe, 0);
      chk("rst_mid_dat_oe", ps2_dat_oe, 0);
      chk("rst_mid_ready", tx_ready, 1);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      start_tx(8'hF4);
      wait_release(low);
      d0 = done_cnt;
      dev_falls(11, 1'b0, oe);
      repeat (2) @(negedge clock);
      chk("after_rst_oe", oe, 10'h10B);
      chk("after_rst_done", done_cnt - d0, 1);

      // tx_valid held with 0xAA during a transfer: no restart until IDLE.
      start_tx(8'hED);
      wait_release(low);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      dev_falls(10, 1'b0, oe);
      chk("held_first_oe", oe, 10'h012);
      dev_dat = 1'b0;
      repeat (HP) @(negedge clock);
      dev_clk = 1'b0;
      n = 0;
      while (!tx_done && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("held_done_seen", tx_done, 1);
      chk("held_ready_at_idle", tx_ready, 1);
      @(negedge clock);
      tx_valid = 1'b0;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      chk("held_restart_busy", busy, 1);
      wait_release(low);
      chk("held_second_inhibit", low, INH + SET);
      d0 = done_cnt;
      dev_falls(11, 1'b0, oe);
      repeat (2) @(negedge clock);
      chk("held_second_oe", oe, 10'h055);
      chk("held_second_done", done_cnt - d0, 1);

      chk("pulse_overlap", overlap_seen, 0);
      chk("pulse_width", long_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
